word_match_scorer: RTL
======================

// Module: word_match_scorer
// PURPOSE
//  Multi-channel, sequential successor to the single-word match scorer. Each accepted word
//  scores every channel with the fixed priority table and adds the result to that channel's total.
//  Consecutive full matches earn a streak bonus. After ROUND_LEN words the block reports
//  per-channel totals and the winning channel over a valid/ready handshake, then clears for the next round.
// PARAMETERS
//  CHANNELS   4   number of independent match channels (>=2)
//  SCORE_W    17  width of each per-channel running total (saturating)
//  ROUND_LEN  8   accepted words per round (>=1)
//  STREAK_N   3   consecutive full matches that trigger a bonus (>=2)
//  BONUS      4   extra points added on the STREAK_N-th consecutive full match
// PORTS
//  clk          in   1                 rising-edge clock
//  rst_n        in   1                 asynchronous, active-low reset
//  clear        in   1                 synchronous soft clear (abort the current round)
//  in_valid     in   1                 word-match flags valid this cycle
//  in_ready     out  1                 block can accept a word
//  full_match   in   CHANNELS          per-channel full-word match
//  first_half   in   CHANNELS          per-channel first-half match (carried, unscored)
//  second_half  in   CHANNELS          per-channel second-half match
//  flag         in   CHANNELS          per-channel bonus flag
//  out_valid    out  1                 round result available
//  out_ready    in   1                 consumer takes the result
//  totals       out  CHANNELS*SCORE_W  channel c at [c*SCORE_W +: SCORE_W]
//  winner       out  clog2(CHANNELS)   index of the highest total (lowest index on a tie)
//  word_cnt     out  clog2(ROUND_LEN+1)  words accepted in the current round
// BEHAVIOUR
//  Reset (rst_n=0, async): state=ACCUM, totals=0, streaks=0, word_cnt=0, out_valid=0, in_ready=1.
//  Per-word score, per channel, evaluated in priority order:
//   second_half&flag -> 10; else full_match -> 8; else second_half -> 5; else -> 2.
//  Streak: per-channel counter.
//   - Increments on each accepted word with full_match=1; resets to 0 otherwise.
//   - Reaching STREAK_N adds BONUS to that word's score, then the counter resets to 0.
//  Accept: in_valid & in_ready. Totals, streaks and word_cnt update on the same clock edge.
//   Latency is 1 cycle: the new values are visible the cycle after acceptance.
//  Arithmetic: total + score saturates at 2^SCORE_W-1, then holds. No wrap.
//  FSM, 2 states:
//   ACCUM:  in_ready=1, out_valid=0.
//           An accept with word_cnt==ROUND_LEN-1 moves to REPORT; word_cnt then reads ROUND_LEN.
//   REPORT: in_ready=0, out_valid=1. totals and winner are stable until the handshake.
//           out_valid & out_ready -> next cycle: ACCUM, totals=0, streaks=0, word_cnt=0.
//  winner: combinational compare of registered totals; meaningful only while out_valid=1.
//  clear: highest priority, any state. Next cycle matches the reset state.
//   A word presented in the same cycle as clear is discarded.
//   A pending REPORT is dropped (out_valid falls without a handshake).
//  in_valid during REPORT: ignored; the source must hold the word (in_ready=0).
//  out_ready during ACCUM: ignored.
//  first_half: does not affect the score. Retained for interface compatibility.
//  ROUND_LEN=1: every accept goes directly to REPORT.
// STRUCTURE
//  Package word_match_pkg:
//   - score constants SC_FLAG=10, SC_FULL=8, SC_SECOND=5, SC_MISS=2
//   - state enum {ST_ACCUM, ST_REPORT}
//  Sub-module word_score_lut: combinational per-channel score (4 flags -> 4-bit score).
//   Instantiated CHANNELS times in a generate loop.
//  Top level holds the FSM, streak counters, saturating adders, word counter and argmax tree.
// TESTING
//  1. Reset mid-round: 3 words accepted, pulse rst_n low
//     -> totals=0, word_cnt=0, in_ready=1, out_valid=0 immediately (async).
//  2. CHANNELS=4, ROUND_LEN=8; ch0 second_half&flag every word, others no flags
//     -> out_valid after 8th accept; totals={16,16,16,80}; winner=0.
//  3. Streak: ch1 full_match on 3 consecutive words, then 5 misses
//     -> ch1 total=8+8+(8+4)+5*2=38.
//  4. Back-pressure: hold out_ready=0 for 5 cycles in REPORT with in_valid=1
//     -> in_ready=0, totals/winner stable; out_ready=1 -> next cycle totals=0, ACCUM.
//  5. Saturation: SCORE_W=5, ROUND_LEN=8, all flag&second_half -> every total=31, not 80 mod 32.
//  6. clear asserted with in_valid in REPORT -> word discarded, out_valid=0, totals=0 next cycle.
//  Tie: equal totals on ch2 and ch3 -> winner=2.

Source files
------------

// File: rtl/word_match_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : word_match_pkg
//  Description : Shared definitions for the word match scorer: per-word
//                score constants and the round FSM state type.
//  Contents    : SC_FLAG / SC_FULL / SC_SECOND / SC_MISS score values,
//                state_t {ST_ACCUM, ST_REPORT}
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
package word_match_pkg;

    localparam logic [3:0] SC_FLAG   = 4'd10;
    localparam logic [3:0] SC_FULL   = 4'd8;
    localparam logic [3:0] SC_SECOND = 4'd5;
    localparam logic [3:0] SC_MISS   = 4'd2;

    typedef enum logic [0:0] {
        ST_ACCUM  = 1'b0,
        ST_REPORT = 1'b1
    } state_t;

endpackage : word_match_pkg
`default_nettype wire

// File: rtl/word_score_lut.sv
`default_nettype none
// ============================================================================
//  Module      : word_score_lut
//  Description : Combinational score for one channel and one word, taken
//                from the fixed priority table.
//  Ports       : i_fullMatch  - full-word match
//                i_firstHalf  - first-half match (carried, never scored)
//                i_secondHalf - second-half match
//                i_flag       - bonus flag
//                o_score      - 4-bit base score (streak bonus excluded)
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module word_score_lut
    import word_match_pkg::*;
(
    input  logic       i_fullMatch,
    input  logic       i_firstHalf,
    input  logic       i_secondHalf,
    input  logic       i_flag,
    output logic [3:0] o_score
);

    // First-half matches are part of the legacy interface but earn nothing.
    logic w_unusedFirstHalf;
    assign w_unusedFirstHalf = i_firstHalf;

    always_comb begin
        o_score = SC_MISS;
        if (i_secondHalf && i_flag) begin
            o_score = SC_FLAG;
        end else if (i_fullMatch) begin
            o_score = SC_FULL;
        end else if (i_secondHalf) begin
            o_score = SC_SECOND;
        end
    end

endmodule : word_score_lut
`default_nettype wire

// File: rtl/word_match_scorer.sv
`default_nettype none
// ============================================================================
//  Module      : word_match_scorer
//  Description : Multi-channel round scorer. Every accepted word adds a
//                per-channel score (plus a streak bonus) to saturating
//                totals; after ROUND_LEN words the totals and the winning
//                channel are offered over a valid/ready handshake.
//  Ports       : clk, rst_n (async, active-low), clear (sync abort)
//                in_valid/in_ready, full_match, first_half, second_half,
//                flag                     - word input, one bit per channel
//                out_valid/out_ready      - round result handshake
//                totals                   - channel c at [c*SCORE_W +: SCORE_W]
//                winner                   - highest total, lowest index on tie
//                word_cnt                 - words accepted this round
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module word_match_scorer
    import word_match_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int SCORE_W   = 17,
    parameter int ROUND_LEN = 8,
    parameter int STREAK_N  = 3,
    parameter int BONUS     = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [CHANNELS-1:0]              full_match,
    input  logic [CHANNELS-1:0]              first_half,
    input  logic [CHANNELS-1:0]              second_half,
    input  logic [CHANNELS-1:0]              flag,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CHANNELS*SCORE_W-1:0]      totals,
    output logic [$clog2(CHANNELS)-1:0]      winner,
    output logic [$clog2(ROUND_LEN+1)-1:0]   word_cnt
);

    localparam int CNT_W = $clog2(ROUND_LEN + 1);
    localparam int WIN_W = $clog2(CHANNELS);
    localparam int STK_W = $clog2(STREAK_N + 1);
    // Sums are formed 33 bits wide so total + score + bonus can never wrap
    // before the saturation compare.
    localparam logic [32:0] SAT_MAX = 33'((64'd1 << SCORE_W) - 64'd1);

    state_t                             r_state;
    state_t                             w_stateNext;
    logic [CHANNELS-1:0][SCORE_W-1:0]   r_total;
    logic [CHANNELS-1:0][STK_W-1:0]     r_streak;
    logic [CNT_W-1:0]                   r_wordCnt;
    logic [CHANNELS-1:0][SCORE_W-1:0]   w_totalNext;
    logic [CHANNELS-1:0][STK_W-1:0]     w_streakNext;
    logic                               w_accept;
    logic                               w_release;
    logic [SCORE_W-1:0]                 w_best;

    // clear discards any word presented alongside it.
    assign w_accept  = in_valid && (r_state == ST_ACCUM) && !clear;
    assign w_release = (r_state == ST_REPORT) && out_ready;
    assign word_cnt  = r_wordCnt;

    // ------------------------------------------------------------------
    // Per-channel score, streak and saturating accumulate
    // ------------------------------------------------------------------
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [3:0]  w_base;
        logic        w_streakHit;
        logic [32:0] w_sum;

        word_score_lut u_lut (
            .i_fullMatch  (full_match[c]),
            .i_firstHalf  (first_half[c]),
            .i_secondHalf (second_half[c]),
            .i_flag       (flag[c]),
            .o_score      (w_base)
        );

        // This full match is the STREAK_N-th in a row.
        assign w_streakHit = full_match[c] && (r_streak[c] == STK_W'(STREAK_N - 1));

        assign w_sum = 33'(r_total[c]) + 33'(w_base)
                     + (w_streakHit ? 33'(BONUS) : 33'd0);

        assign w_totalNext[c]  = (w_sum > SAT_MAX) ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
        assign w_streakNext[c] = (!full_match[c] || w_streakHit) ? '0
                               : r_streak[c] + STK_W'(1);

        assign totals[c*SCORE_W +: SCORE_W] = r_total[c];
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (w_accept && (r_wordCnt == CNT_W'(ROUND_LEN - 1))) begin
                    w_stateNext = ST_REPORT;
                end
            end
            ST_REPORT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_stateNext = ST_ACCUM;
                end
            end
            default: w_stateNext = ST_ACCUM;
        endcase
        if (clear) begin
            w_stateNext = ST_ACCUM;
        end
    end

    // ------------------------------------------------------------------
    // Totals, streaks and word counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total   <= '0;
            r_streak  <= '0;
            r_wordCnt <= '0;
        end else if (clear || w_release) begin
            r_total   <= '0;
            r_streak  <= '0;
            r_wordCnt <= '0;
        end else if (w_accept) begin
            r_total   <= w_totalNext;
            r_streak  <= w_streakNext;
            r_wordCnt <= r_wordCnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Argmax: strict greater-than keeps the lowest index on a tie.
    // ------------------------------------------------------------------
    always_comb begin
        w_best = r_total[0];
        winner = '0;
        for (int c = 1; c < CHANNELS; c++) begin
            if (r_total[c] > w_best) begin
                w_best = r_total[c];
                winner = WIN_W'(c);
            end
        end
    end

endmodule : word_match_scorer
`default_nettype wire
